// File: rtl/f1_pkg.sv
// f1_pkg: shared types and defaults for the F1 reaction timer.
package f1_pkg;
  localparam int CNT_W_DEF  = 16;
  localparam int MAX_MS_DEF = 9999;
  localparam int MIN_MS_DEF = 100;
  typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FALSE} rt_state_t;
endpackage

// File: rtl/edge_detect.sv
// edge_detect: one-cycle pulse on a rising edge of a level input (ports: clk, rst, level in; pulse out).
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);
  logic level_q;
  always_ff @(posedge clk)
    level_q <= rst ? 1'b0 : level;
  assign pulse = level & ~level_q;
endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: measures ms from lights-out to button press and tracks session best (ports: clk, rst, tick_ms, arm, lights_out, stop, clear_best in; time_ms, best_ms, timing, result_valid, false_start, new_best out).
module reaction_timer
  import f1_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int MAX_MS = MAX_MS_DEF,
  parameter int MIN_MS = MIN_MS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_ms,
  input  logic             arm,
  input  logic             lights_out,
  input  logic             stop,
  input  logic             clear_best,
  output logic [CNT_W-1:0] time_ms,
  output logic [CNT_W-1:0] best_ms,
  output logic             timing,
  output logic             result_valid,
  output logic             false_start,
  output logic             new_best
);
  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_MS);
  localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_MS);
  rt_state_t state, state_n;
  logic press, early, valid_press, timeout;
  edge_detect u_edge (.clk(clk), .rst(rst), .level(stop), .pulse(press));
  assign early       = time_ms < MIN_V;
  assign valid_press = state == TIMING && press && !early && !arm;
  // The count leaves TIMING on the tick that lands it on MAX_MS, so it can never pass it.
  assign timeout     = state == TIMING && !press && tick_ms && time_ms == MAX_V - 1'b1 && !arm;
  assign timing      = state == TIMING;
  always_comb begin
    state_n = state;
    case (state)
      ARMED:   state_n = press ? FALSE : lights_out ? TIMING : ARMED;
      TIMING:  state_n = press ? (early ? FALSE : DONE) : timeout ? DONE : TIMING;
      default: state_n = state;
    endcase
    if (arm) state_n = ARMED;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      time_ms      <= '0;
      best_ms      <= MAX_V;
      result_valid <= 1'b0;
      false_start  <= 1'b0;
      new_best     <= 1'b0;
    end else begin
      new_best <= 1'b0;
      if (arm) begin
        time_ms      <= '0;
        result_valid <= 1'b0;
        false_start  <= 1'b0;
      end else if (state == ARMED && press) begin
        false_start <= 1'b1;
        time_ms     <= '0;
      end else if (state == TIMING) begin
        if (press) begin
          false_start  <= early;
          result_valid <= !early;
        end else if (tick_ms) begin
          time_ms      <= time_ms + 1'b1;
          result_valid <= timeout;
        end
      end
      if (clear_best)
        best_ms <= MAX_V;
      else if (valid_press && time_ms < best_ms) begin
        best_ms  <= time_ms;
        new_best <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: directed self-checking bench for reaction_timer.
module tb_reaction_timer;
  logic clk = 1'b0, rst = 1'b1, tick_ms = 1'b0, arm = 1'b0, lights_out = 1'b0, stop = 1'b0, clear_best = 1'b0;
  logic [15:0] time_ms, best_ms;
  logic timing, result_valid, false_start, new_best;
  int errors = 0, checks = 0, nb_cnt = 0;
  reaction_timer dut (
    .clk(clk), .rst(rst), .tick_ms(tick_ms), .arm(arm), .lights_out(lights_out), .stop(stop),
    .clear_best(clear_best), .time_ms(time_ms), .best_ms(best_ms), .timing(timing),
    .result_valid(result_valid), .false_start(false_start), .new_best(new_best)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (new_best === 1'b1) nb_cnt++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  task automatic do_rst();
    rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
  endtask
  task automatic do_arm();
    arm = 1'b1; cyc(1); arm = 1'b0; cyc(1);
  endtask
  task automatic do_lo();
    lights_out = 1'b1; cyc(1); lights_out = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1; cyc(1); tick_ms = 1'b0;
    end
  endtask
  task automatic press();
    stop = 1'b1; cyc(1); stop = 1'b0; cyc(1);
  endtask
  task automatic run(input int n);
    do_arm(); do_lo(); ticks(n); press();
  endtask
  initial begin
    cyc(1);
    do_rst();
    chk("rst_time", time_ms, 0);
    chk("rst_best", best_ms, 9999);
    chk("rst_timing", timing, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_fs", false_start, 0);
    chk("rst_nb", new_best, 0);
    nb_cnt = 0;
    do_arm(); do_lo();
    chk("norm_timing_on", timing, 1);
    ticks(250); press();
    chk("norm_time", time_ms, 250);
    chk("norm_valid", result_valid, 1);
    chk("norm_best", best_ms, 250);
    chk("norm_timing_off", timing, 0);
    chk("norm_nb_cnt", nb_cnt, 1);
    do_rst();
    do_arm(); press();
    chk("jump_fs", false_start, 1);
    chk("jump_time", time_ms, 0);
    chk("jump_best", best_ms, 9999);
    do_lo(); ticks(3);
    chk("jump_hold_time", time_ms, 0);
    do_arm();
    chk("rearm_fs_clr", false_start, 0);
    stop = 1'b1; lights_out = 1'b1; cyc(1); stop = 1'b0; lights_out = 1'b0; cyc(1);
    chk("same_fs", false_start, 1);
    chk("same_timing", timing, 0);
    chk("same_time", time_ms, 0);
    run(99);
    chk("antic_fs", false_start, 1);
    chk("antic_time", time_ms, 99);
    chk("antic_valid", result_valid, 0);
    chk("antic_best", best_ms, 9999);
    run(100);
    chk("min_fs", false_start, 0);
    chk("min_valid", result_valid, 1);
    chk("min_time", time_ms, 100);
    chk("min_best", best_ms, 100);
    do_rst(); nb_cnt = 0;
    do_arm(); do_lo(); ticks(9998);
    chk("to_pre_timing", timing, 1);
    chk("to_pre_valid", result_valid, 0);
    ticks(1);
    chk("to_time", time_ms, 9999);
    chk("to_valid", result_valid, 1);
    chk("to_timing", timing, 0);
    ticks(5); press();
    chk("to_sat", time_ms, 9999);
    chk("to_fs", false_start, 0);
    chk("to_best", best_ms, 9999);
    chk("to_nb_cnt", nb_cnt, 0);
    do_rst(); nb_cnt = 0;
    run(300); run(200); run(200); run(400);
    chk("bt_best", best_ms, 200);
    chk("bt_nb_cnt", nb_cnt, 2);
    clear_best = 1'b1; cyc(1); clear_best = 1'b0;
    chk("bt_clear", best_ms, 9999);
    nb_cnt = 0;
    do_arm(); do_lo(); ticks(150);
    stop = 1'b1; clear_best = 1'b1; cyc(1); stop = 1'b0; clear_best = 1'b0; cyc(1);
    chk("clr_win_best", best_ms, 9999);
    chk("clr_win_nb", nb_cnt, 0);
    chk("clr_win_time", time_ms, 150);
    stop = 1'b1; cyc(3);
    do_arm(); do_lo(); ticks(10);
    chk("held_fs", false_start, 0);
    chk("held_timing", timing, 1);
    stop = 1'b0; cyc(1);
    ticks(140);
    stop = 1'b1; tick_ms = 1'b1; cyc(1); stop = 1'b0; tick_ms = 1'b0; cyc(1);
    chk("pt_time", time_ms, 150);
    chk("pt_valid", result_valid, 1);
    chk("pt_best", best_ms, 150);
    do_arm(); do_lo(); ticks(20);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("mrst_time", time_ms, 0);
    chk("mrst_timing", timing, 0);
    chk("mrst_best", best_ms, 9999);
    chk("mrst_valid", result_valid, 0);
    ticks(5); press();
    chk("mrst_idle_fs", false_start, 0);
    chk("mrst_idle_time", time_ms, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Downstream consumer of the F1 light-sequence FSM.
- Timing starts when the last red light goes out. Timing stops on the driver's button press.
- Outputs the reaction time and the session best time in milliseconds, in binary, to the bin2bcd_16 / hexto7seg display path.
- Flags false starts (press before lights out, or faster than human-possible) and timeouts.

Parameters:
- CNT_W, 16, width of the time_ms and best_ms outputs.
- MAX_MS, 9999, saturation/timeout value; 4 display digits.
- MIN_MS, 100, a reaction below this many ms is classed as a false start.

Ports:
- clk  in  1  system clock; all logic runs on it.
- rst  in  1  synchronous, active-high reset.
- tick_ms  in  1  1-cycle enable pulse, once per ms (clktick output).
- arm  in  1  1-cycle pulse: light sequence has started.
- lights_out  in  1  1-cycle pulse: all lights have gone off (FSM time_out).
- stop  in  1  button level, active-high (already inverted KEY); edge-detected internally.
- clear_best  in  1  1-cycle pulse: set best_ms back to MAX_MS.
- time_ms  out  CNT_W  current or captured reaction time.
- best_ms  out  CNT_W  fastest valid reaction since reset or clear.
- timing  out  1  high while the count is running.
- result_valid  out  1  high while time_ms holds a final result.
- false_start  out  1  high while the last attempt is a false start.
- new_best  out  1  1-cycle pulse when best_ms is updated.

Behaviour:
- Reset values:
  - state IDLE, time_ms=0, best_ms=MAX_MS.
  - timing, result_valid, false_start and new_best all 0.
  - stop edge register = 0.
- Press detection: press = stop & ~stop_q. stop_q is registered every cycle. A held button never produces a second press.
- States: IDLE, ARMED, TIMING, DONE, FALSE. State is encoded as an enum.
- Transitions:
  - arm in any state → ARMED. On that transition: time_ms←0, result_valid←0, false_start←0.
  - ARMED: press → FALSE (false_start←1, time_ms←0).
  - ARMED: lights_out without press → TIMING, timing=1.
  - ARMED: press and lights_out in the same cycle → FALSE.
  - TIMING: on each tick_ms, time_ms←time_ms+1.
  - TIMING: press with time_ms<MIN_MS → FALSE. time_ms keeps the captured value.
  - TIMING: press with time_ms≥MIN_MS → DONE, result_valid←1, time_ms frozen.
  - TIMING: press and tick_ms in the same cycle → the press wins and that tick is not counted.
  - TIMING: time_ms reaching MAX_MS → DONE, time_ms=MAX_MS, result_valid←1. A timeout never updates best.
  - DONE or FALSE: hold until arm. lights_out and press are ignored.
  - IDLE: everything except arm is ignored.
- Best update, in the cycle DONE is entered by a valid press:
  - if time_ms<best_ms: best_ms←time_ms and new_best=1 for exactly 1 cycle.
  - equal times do not update best.
- clear_best: best_ms←MAX_MS. If clear_best coincides with a best update, clear wins and there is no new_best pulse.
- Latency: stop rising at clock edge N → state, result_valid and time_ms are updated at edge N+1.
- Arithmetic: unsigned CNT_W. The counter never exceeds MAX_MS and never wraps.
- rst mid-operation: immediate return to IDLE with all reset values, including best_ms.
- Outputs are registered (timing is decoded from state). No combinational path from stop to any output.

Decomposition:
- Shared package f1_pkg holds:
  - the state enum type: rt_state_t {IDLE, ARMED, TIMING, DONE, FALSE};
  - localparams for default MAX_MS and MIN_MS;
  - CNT_W default.
- One natural sub-module: edge_detect, a rising-edge pulse from a level, reusable for KEY inputs elsewhere.
- The counter and best register stay inline.

Test Plan:
- Normal reaction: rst, arm, lights_out, 250 ticks then stop rising → time_ms=250, result_valid=1, best_ms=250, one new_best pulse, timing=0.
- Jump start: arm, stop rising before lights_out → false_start=1, time_ms=0, best_ms unchanged (9999). Same result for stop and lights_out in the same cycle.
- Anticipation: lights_out, press after 99 ticks → false_start=1, time_ms=99, best unchanged. Press after exactly 100 ticks → valid, time_ms=100.
- Timeout: lights_out, 9999 ticks with no press → time_ms=9999, result_valid=1, no new_best. Further ticks leave the value at 9999.
- Best tracking: valid attempts of 300, 200, 200, 400 → best_ms=200 with exactly two new_best pulses. Then clear_best → best_ms=9999.
- Held button and edge cases:
  - stop held high through arm/lights_out → no false start; a later release/re-press counts.
  - press and tick in the same cycle at count 150 → time_ms=150.
  - rst during TIMING → IDLE, outputs at reset values.
